// File: rtl/ladybird_uart_pkg.sv
// Shared parity mode constants, FSM state encodings and parity helper
// for the ladybird UART bridge.
package ladybird_uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/ladybird_fifo.sv
// First-word-fall-through FIFO: rd_data always shows the head entry.
module ladybird_fifo #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH_W = 3
) (
    input  logic             clk,
    input  logic             anrst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**DEPTH_W];
    logic [DEPTH_W:0] wr_ptr;
    logic [DEPTH_W:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[DEPTH_W] != rd_ptr[DEPTH_W]) &&
                     (wr_ptr[DEPTH_W-1:0] == rd_ptr[DEPTH_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[DEPTH_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[DEPTH_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ladybird_uart_rx_engine.sv
// UART receive bit engine: synchronises the line, finds start edges and
// delivers one byte per frame with its parity/framing error flag.
//
// state     | meaning
// RX_IDLE   | waiting for a 1->0 edge on the synchronised line
// RX_START  | counting to the start-bit midpoint, reject false starts
// RX_DATA   | sampling 8 data bits LSB-first
// RX_PARITY | sampling and checking the parity bit
// RX_STOP   | sampling the first stop bit, then back to idle
module ladybird_uart_rx_engine
    import ladybird_uart_pkg::*;
#(
    parameter int unsigned WTIME  = 16'h364,
    parameter int unsigned PARITY = 0
) (
    input  logic       clk,
    input  logic       anrst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       idle,
    output logic       start
);

    localparam logic [15:0] W_M1    = 16'(WTIME - 1);
    localparam logic [15:0] HALF_M1 = 16'(WTIME / 2 - 1);

    // [1:0] is the synchroniser, [2] holds the previous synchronised value
    logic [2:0]  sync_q;
    logic        line;
    logic        fall;
    rx_state_t   state;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_err;

    assign line  = sync_q[1];
    assign fall  = sync_q[2] && !line;
    assign idle  = (state == RX_IDLE);
    assign start = idle && fall;

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            sync_q     <= 3'b111;
            state      <= RX_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_err    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_err   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], rxd};
            byte_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        state   <= RX_START;
                        timer   <= HALF_M1;
                        par_err <= 1'b0;
                    end
                end
                RX_START: begin
                    if (timer != 16'd0) timer <= timer - 16'd1;
                    else if (line) state <= RX_IDLE;
                    else begin
                        state   <= RX_DATA;
                        timer   <= W_M1;
                        bit_idx <= '0;
                    end
                end
                RX_DATA: begin
                    if (timer != 16'd0) timer <= timer - 16'd1;
                    else begin
                        shreg   <= {line, shreg[7:1]};
                        timer   <= W_M1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (timer != 16'd0) timer <= timer - 16'd1;
                    else begin
                        par_err <= line ^ parity_bit(shreg, PARITY);
                        timer   <= W_M1;
                        state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (timer != 16'd0) timer <= timer - 16'd1;
                    else begin
                        byte_valid <= 1'b1;
                        byte_data  <= shreg;
                        byte_err   <= par_err | ~line;
                        state      <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ladybird_uart_bridge.sv
// Word-wide UART bridge: TX FIFO feeding a framing FSM, RX bit engine
// assembling words into an RX FIFO, with partial-word timeout and overflow count.
//
// state     | meaning
// TX_IDLE   | line at 1, waiting for a word in the TX FIFO
// TX_START  | driving the start bit
// TX_DATA   | driving 8 data bits LSB-first
// TX_PARITY | driving the parity bit
// TX_STOP   | driving stop bits, then next byte, next word or idle
module ladybird_uart_bridge
    import ladybird_uart_pkg::*;
#(
    parameter int unsigned WTIME        = 16'h364,
    parameter int unsigned I_BYTES      = 1,
    parameter int unsigned O_BYTES      = 1,
    parameter int unsigned FIFO_DEPTH_W = 3,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned RX_TIMEOUT   = 4
) (
    input  logic                 clk,
    input  logic                 anrst,
    input  logic                 uart_txd_in,
    output logic                 uart_rxd_out,
    input  logic [I_BYTES*8-1:0] i_data,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [O_BYTES*8-1:0] o_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_err,
    output logic                 rx_timeout,
    output logic [7:0]           overflow_cnt,
    input  logic                 err_clr
);

    localparam int unsigned IW  = I_BYTES * 8;
    localparam int unsigned OW  = O_BYTES * 8;
    localparam int unsigned IBW = (I_BYTES > 1) ? $clog2(I_BYTES) : 1;
    localparam int unsigned OBW = (O_BYTES > 1) ? $clog2(O_BYTES) : 1;
    localparam logic [IBW-1:0] I_LAST    = IBW'(I_BYTES - 1);
    localparam logic [OBW-1:0] O_LAST    = OBW'(O_BYTES - 1);
    localparam logic [15:0]    W_M1      = 16'(WTIME - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);
    localparam bit             TO_EN     = (RX_TIMEOUT != 0);
    localparam logic [31:0]    TO_LIMIT  =
        32'(RX_TIMEOUT * (10 + ((PARITY != PAR_NONE) ? 1 : 0)) * WTIME);
    localparam logic [31:0]    TO_LAST   = TO_LIMIT - 32'd1;

    logic [IW-1:0] tx_head;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_pop;
    tx_state_t     tx_state;
    logic [15:0]   tx_timer;
    logic [2:0]    tx_bit;
    logic [IBW-1:0] tx_byte_idx;
    logic [IW-1:0] tx_word;
    logic [7:0]    tx_cur;
    logic          tx_stop;
    logic          tx_bit_end;

    assign i_ready    = !tx_full;
    assign tx_bit_end = (tx_timer == 16'd0);
    assign tx_pop     = !tx_empty &&
                        ((tx_state == TX_IDLE) ||
                         (tx_state == TX_STOP && tx_bit_end &&
                          tx_stop == STOP_LAST && tx_byte_idx == I_LAST));

    ladybird_fifo #(.WIDTH(IW), .DEPTH_W(FIFO_DEPTH_W)) u_tx_fifo (
        .clk     (clk),
        .anrst   (anrst),
        .wr_en   (i_valid),
        .wr_data (i_data),
        .full    (tx_full),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .empty   (tx_empty)
    );

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            tx_state     <= TX_IDLE;
            tx_timer     <= '0;
            tx_bit       <= '0;
            tx_byte_idx  <= '0;
            tx_word      <= '0;
            tx_cur       <= '0;
            tx_stop      <= 1'b0;
            uart_rxd_out <= 1'b1;
        end else begin
            if (!tx_bit_end) tx_timer <= tx_timer - 16'd1;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_word      <= tx_head >> 8;
                        tx_cur       <= tx_head[7:0];
                        tx_byte_idx  <= '0;
                        tx_timer     <= W_M1;
                        tx_state     <= TX_START;
                        uart_rxd_out <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state     <= TX_DATA;
                        tx_timer     <= W_M1;
                        tx_bit       <= '0;
                        uart_rxd_out <= tx_cur[0];
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_timer <= W_M1;
                        if (tx_bit != 3'd7) begin
                            tx_bit       <= tx_bit + 3'd1;
                            uart_rxd_out <= tx_cur[tx_bit + 3'd1];
                        end else if (PARITY != PAR_NONE) begin
                            tx_state     <= TX_PARITY;
                            uart_rxd_out <= parity_bit(tx_cur, PARITY);
                        end else begin
                            tx_state     <= TX_STOP;
                            tx_stop      <= 1'b0;
                            uart_rxd_out <= 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_state     <= TX_STOP;
                        tx_timer     <= W_M1;
                        tx_stop      <= 1'b0;
                        uart_rxd_out <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_stop != STOP_LAST) begin
                            tx_stop  <= 1'b1;
                            tx_timer <= W_M1;
                        end else if (tx_byte_idx != I_LAST) begin
                            tx_byte_idx  <= tx_byte_idx + 1'b1;
                            tx_cur       <= tx_word[7:0];
                            tx_word      <= tx_word >> 8;
                            tx_timer     <= W_M1;
                            tx_state     <= TX_START;
                            uart_rxd_out <= 1'b0;
                        end else if (tx_pop) begin
                            tx_word      <= tx_head >> 8;
                            tx_cur       <= tx_head[7:0];
                            tx_byte_idx  <= '0;
                            tx_timer     <= W_M1;
                            tx_state     <= TX_START;
                            uart_rxd_out <= 1'b0;
                        end else begin
                            tx_state     <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           byte_err;
    logic           rx_idle;
    logic           rx_start;
    logic [OW-1:0]  rx_partial;
    logic [OW-1:0]  rx_word;
    logic [OBW-1:0] rx_cnt;
    logic           rx_err_acc;
    logic [31:0]    idle_cnt;
    logic           rx_push;
    logic           rx_full;
    logic           rx_empty;
    logic [OW:0]    rx_head;
    logic           ovf_event;

    ladybird_uart_rx_engine #(.WTIME(WTIME), .PARITY(PARITY)) u_rx_engine (
        .clk        (clk),
        .anrst      (anrst),
        .rxd        (uart_txd_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .idle       (rx_idle),
        .start      (rx_start)
    );

    always_comb begin
        rx_word = rx_partial;
        for (int k = 0; k < O_BYTES; k++) begin
            if (OBW'(k) == rx_cnt) rx_word[8*k +: 8] = byte_data;
        end
    end

    assign rx_push   = byte_valid && (rx_cnt == O_LAST);
    assign ovf_event = rx_push && rx_full;

    ladybird_fifo #(.WIDTH(OW + 1), .DEPTH_W(FIFO_DEPTH_W)) u_rx_fifo (
        .clk     (clk),
        .anrst   (anrst),
        .wr_en   (rx_push),
        .wr_data ({rx_err_acc | byte_err, rx_word}),
        .full    (rx_full),
        .rd_en   (o_ready),
        .rd_data (rx_head),
        .empty   (rx_empty)
    );

    assign o_valid = !rx_empty;
    assign o_data  = rx_head[OW-1:0];
    assign o_err   = !rx_empty && rx_head[OW];

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            rx_partial <= '0;
            rx_cnt     <= '0;
            rx_err_acc <= 1'b0;
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            rx_timeout <= 1'b0;
            if (byte_valid) begin
                idle_cnt <= '0;
                if (rx_push) begin
                    rx_cnt     <= '0;
                    rx_err_acc <= 1'b0;
                end else begin
                    rx_cnt     <= rx_cnt + 1'b1;
                    rx_partial <= rx_word;
                    rx_err_acc <= rx_err_acc | byte_err;
                end
            end else if (!TO_EN || rx_cnt == '0 || !rx_idle) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TO_LAST) begin
                idle_cnt <= '0;
                // a start edge on the final idle cycle keeps the partial word
                if (!rx_start) begin
                    rx_cnt     <= '0;
                    rx_err_acc <= 1'b0;
                    rx_partial <= '0;
                    rx_timeout <= 1'b1;
                end
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) overflow_cnt <= '0;
        else if (ovf_event) begin
            if (err_clr) overflow_cnt <= 8'd1;
            else if (overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
        end else if (err_clr) overflow_cnt <= '0;
    end

endmodule

// File: tb/tb_ladybird_uart_bridge.sv
// Directed bench for ladybird_uart_bridge: four configurations sharing one
// clock and reset, each scenario a task with inline checks.
module tb_ladybird_uart_bridge;

    logic clk = 1'b0;
    logic anrst = 1'b0;
    logic [3:0] rxl = 4'hF;
    logic err_clr = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // A: 2-byte TX words, RX looped back from its own TX line
    logic [15:0] i_data_a = 16'h0000;
    logic i_valid_a = 1'b0, o_ready_a = 1'b0;
    logic i_ready_a, txd_a, o_valid_a, o_err_a, to_a;
    logic [7:0] o_data_a, ovf_a;
    // B: even parity
    logic o_ready_b = 1'b0;
    logic i_ready_b, txd_b, o_valid_b, o_err_b, to_b;
    logic [7:0] o_data_b, ovf_b;
    // C: 4-byte RX words, 2-entry FIFOs
    logic o_ready_c = 1'b0;
    logic i_ready_c, txd_c, o_valid_c, o_err_c, to_c;
    logic [31:0] o_data_c;
    logic [7:0] ovf_c;
    // D: 2-byte RX words, one-frame timeout
    logic o_ready_d = 1'b0;
    logic i_ready_d, txd_d, o_valid_d, o_err_d, to_d;
    logic [15:0] o_data_d;
    logic [7:0] ovf_d;

    ladybird_uart_bridge #(.WTIME(16), .I_BYTES(2)) u_a (
        .clk(clk), .anrst(anrst), .uart_txd_in(txd_a), .uart_rxd_out(txd_a),
        .i_data(i_data_a), .i_valid(i_valid_a), .i_ready(i_ready_a),
        .o_data(o_data_a), .o_valid(o_valid_a), .o_ready(o_ready_a), .o_err(o_err_a),
        .rx_timeout(to_a), .overflow_cnt(ovf_a), .err_clr(err_clr));

    ladybird_uart_bridge #(.WTIME(16), .PARITY(1)) u_b (
        .clk(clk), .anrst(anrst), .uart_txd_in(rxl[1]), .uart_rxd_out(txd_b),
        .i_data(8'h00), .i_valid(1'b0), .i_ready(i_ready_b),
        .o_data(o_data_b), .o_valid(o_valid_b), .o_ready(o_ready_b), .o_err(o_err_b),
        .rx_timeout(to_b), .overflow_cnt(ovf_b), .err_clr(err_clr));

    ladybird_uart_bridge #(.WTIME(16), .O_BYTES(4), .FIFO_DEPTH_W(1)) u_c (
        .clk(clk), .anrst(anrst), .uart_txd_in(rxl[2]), .uart_rxd_out(txd_c),
        .i_data(8'h00), .i_valid(1'b0), .i_ready(i_ready_c),
        .o_data(o_data_c), .o_valid(o_valid_c), .o_ready(o_ready_c), .o_err(o_err_c),
        .rx_timeout(to_c), .overflow_cnt(ovf_c), .err_clr(err_clr));

    ladybird_uart_bridge #(.WTIME(16), .O_BYTES(2), .RX_TIMEOUT(1)) u_d (
        .clk(clk), .anrst(anrst), .uart_txd_in(rxl[3]), .uart_rxd_out(txd_d),
        .i_data(8'h00), .i_valid(1'b0), .i_ready(i_ready_d),
        .o_data(o_data_d), .o_valid(o_valid_d), .o_ready(o_ready_d), .o_err(o_err_d),
        .rx_timeout(to_d), .overflow_cnt(ovf_d), .err_clr(err_clr));

    // par < 0: no parity bit; otherwise par[0] is the parity bit driven
    task automatic send_byte(input int ln, input logic [7:0] d, input int par, input logic stop);
        rxl[ln] = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxl[ln] = d[i];
            repeat (16) @(negedge clk);
        end
        if (par >= 0) begin
            rxl[ln] = par[0];
            repeat (16) @(negedge clk);
        end
        rxl[ln] = stop;
        repeat (16) @(negedge clk);
        rxl[ln] = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({txd_a, txd_b, txd_c, txd_d} !== 4'hF) begin
            n_fail++; $display("FAIL reset_txd: got %b expected 1111", {txd_a, txd_b, txd_c, txd_d});
        end
        n_checks++;
        if ({o_valid_a, o_valid_b, o_valid_c, o_valid_d, o_err_a, o_err_b, o_err_c, o_err_d} !== 8'h00) begin
            n_fail++; $display("FAIL reset_o_valid_err: got %b expected 00000000",
                {o_valid_a, o_valid_b, o_valid_c, o_valid_d, o_err_a, o_err_b, o_err_c, o_err_d});
        end
        n_checks++;
        if ({to_a, to_b, to_c, to_d} !== 4'h0 || {ovf_a, ovf_b, ovf_c, ovf_d} !== 32'h0) begin
            n_fail++; $display("FAIL reset_timeout_ovf: got to=%b ovf=%h expected 0",
                {to_a, to_b, to_c, to_d}, {ovf_a, ovf_b, ovf_c, ovf_d});
        end
        anrst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({i_ready_a, i_ready_b, i_ready_c, i_ready_d} !== 4'hF) begin
            n_fail++; $display("FAIL reset_i_ready: got %b expected 1111",
                {i_ready_a, i_ready_b, i_ready_c, i_ready_d});
        end
        @(negedge clk);
    endtask

    task automatic test_tx_frames;
        logic [19:0] exp_bits;
        logic [19:0] got_bits;
        int w;
        int errs;
        int zeros;
        exp_bits = {1'b1, 8'hA5, 1'b0, 1'b1, 8'h5A, 1'b0};
        got_bits = '0;
        i_data_a = 16'hA55A;
        i_valid_a = 1'b1;
        @(negedge clk);
        i_valid_a = 1'b0;
        w = 0;
        while (txd_a !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (txd_a !== 1'b0) begin
            n_fail++; $display("FAIL tx_start_wait: line got %b expected 0 within 20 clocks", txd_a);
        end
        errs = 0;
        for (int s = 0; s < 320; s++) begin
            if (txd_a !== exp_bits[s / 16]) errs++;
            if (s % 16 == 8) got_bits[s / 16] = txd_a;
            @(negedge clk);
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++; $display("FAIL tx_waveform: got %0d wrong samples expected 0", errs);
        end
        n_checks++;
        if (got_bits[9:0] !== {1'b1, 8'h5A, 1'b0}) begin
            n_fail++; $display("FAIL tx_frame0: got %b expected %b", got_bits[9:0], {1'b1, 8'h5A, 1'b0});
        end
        n_checks++;
        if (got_bits[19:10] !== {1'b1, 8'hA5, 1'b0}) begin
            n_fail++; $display("FAIL tx_frame1: got %b expected %b", got_bits[19:10], {1'b1, 8'hA5, 1'b0});
        end
        zeros = 0;
        for (int s = 0; s < 40; s++) begin
            if (txd_a !== 1'b1) zeros++;
            @(negedge clk);
        end
        n_checks++;
        if (zeros != 0) begin
            n_fail++; $display("FAIL tx_idle_after: got %0d non-1 samples expected 0", zeros);
        end
        n_checks++;
        if (o_valid_a !== 1'b1 || o_data_a !== 8'h5A || o_err_a !== 1'b0) begin
            n_fail++; $display("FAIL loop_byte0: got v=%b d=%h e=%b expected v=1 d=5a e=0",
                o_valid_a, o_data_a, o_err_a);
        end
        o_ready_a = 1'b1; @(negedge clk); o_ready_a = 1'b0;
        n_checks++;
        if (o_valid_a !== 1'b1 || o_data_a !== 8'hA5 || o_err_a !== 1'b0) begin
            n_fail++; $display("FAIL loop_byte1: got v=%b d=%h e=%b expected v=1 d=a5 e=0",
                o_valid_a, o_data_a, o_err_a);
        end
        o_ready_a = 1'b1; @(negedge clk); o_ready_a = 1'b0;
        n_checks++;
        if (o_valid_a !== 1'b0) begin
            n_fail++; $display("FAIL loop_drained: got o_valid=%b expected 0", o_valid_a);
        end
    endtask

    task automatic test_parity;
        send_byte(1, 8'h07, 1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (o_valid_b !== 1'b1 || o_data_b !== 8'h07 || o_err_b !== 1'b0) begin
            n_fail++; $display("FAIL parity_good: got v=%b d=%h e=%b expected v=1 d=07 e=0",
                o_valid_b, o_data_b, o_err_b);
        end
        o_ready_b = 1'b1; @(negedge clk); o_ready_b = 1'b0;
        send_byte(1, 8'h07, 0, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (o_valid_b !== 1'b1 || o_data_b !== 8'h07 || o_err_b !== 1'b1) begin
            n_fail++; $display("FAIL parity_bad: got v=%b d=%h e=%b expected v=1 d=07 e=1",
                o_valid_b, o_data_b, o_err_b);
        end
        o_ready_b = 1'b1; @(negedge clk); o_ready_b = 1'b0;
    endtask

    task automatic test_framing_and_glitch;
        send_byte(1, 8'h55, 0, 1'b0);
        repeat (16) @(negedge clk);
        n_checks++;
        if (o_valid_b !== 1'b1 || o_data_b !== 8'h55 || o_err_b !== 1'b1) begin
            n_fail++; $display("FAIL stop_error: got v=%b d=%h e=%b expected v=1 d=55 e=1",
                o_valid_b, o_data_b, o_err_b);
        end
        o_ready_b = 1'b1; @(negedge clk); o_ready_b = 1'b0;
        rxl[1] = 1'b0;
        repeat (4) @(negedge clk);
        rxl[1] = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (o_valid_b !== 1'b0) begin
            n_fail++; $display("FAIL glitch_rejected: got o_valid=%b expected 0", o_valid_b);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] words [3];
        logic [31:0] wd;
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        words[2] = 32'h99AABBCC;
        for (int w = 0; w < 3; w++) begin
            wd = words[w];
            for (int b = 0; b < 4; b++) send_byte(2, wd[8*b +: 8], -1, 1'b1);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (ovf_c !== 8'd1) begin
            n_fail++; $display("FAIL overflow_count: got %0d expected 1", ovf_c);
        end
        n_checks++;
        if (o_valid_c !== 1'b1 || o_data_c !== 32'h11223344 || o_err_c !== 1'b0) begin
            n_fail++; $display("FAIL overflow_word0: got v=%b d=%h e=%b expected v=1 d=11223344 e=0",
                o_valid_c, o_data_c, o_err_c);
        end
        o_ready_c = 1'b1; @(negedge clk); o_ready_c = 1'b0;
        n_checks++;
        if (o_valid_c !== 1'b1 || o_data_c !== 32'h55667788) begin
            n_fail++; $display("FAIL overflow_word1: got v=%b d=%h expected v=1 d=55667788",
                o_valid_c, o_data_c);
        end
        o_ready_c = 1'b1; @(negedge clk); o_ready_c = 1'b0;
        n_checks++;
        if (o_valid_c !== 1'b0 || ovf_c !== 8'd1) begin
            n_fail++; $display("FAIL overflow_drained: got v=%b cnt=%0d expected v=0 cnt=1", o_valid_c, ovf_c);
        end
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        n_checks++;
        if (ovf_c !== 8'd0) begin
            n_fail++; $display("FAIL overflow_clear: got %0d expected 0", ovf_c);
        end
    endtask

    task automatic test_timeout;
        int first;
        int width;
        send_byte(3, 8'hC3, -1, 1'b1);
        first = -1;
        width = 0;
        // stop midpoint is sampled about 6 clocks before send_byte returns,
        // so the 160-clock idle count ends about 156 clocks after return
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (to_d === 1'b1) begin
                if (first < 0) first = k;
                width++;
            end
        end
        n_checks++;
        if (first < 150 || first > 162) begin
            n_fail++; $display("FAIL timeout_delay: got pulse at %0d clocks expected 150..162", first);
        end
        n_checks++;
        if (width != 1) begin
            n_fail++; $display("FAIL timeout_width: got %0d cycles expected 1", width);
        end
        n_checks++;
        if (o_valid_d !== 1'b0) begin
            n_fail++; $display("FAIL timeout_discard: got o_valid=%b expected 0", o_valid_d);
        end
        send_byte(3, 8'h34, -1, 1'b1);
        send_byte(3, 8'h12, -1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (o_valid_d !== 1'b1 || o_data_d !== 16'h1234 || o_err_d !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fresh_word: got v=%b d=%h e=%b expected v=1 d=1234 e=0",
                o_valid_d, o_data_d, o_err_d);
        end
        o_ready_d = 1'b1; @(negedge clk); o_ready_d = 1'b0;
    endtask

    task automatic test_reset_mid_tx;
        int w;
        int zeros;
        i_data_a = 16'h0000;
        i_valid_a = 1'b1;
        @(negedge clk);
        i_valid_a = 1'b0;
        w = 0;
        while (txd_a !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (txd_a !== 1'b0) begin
            n_fail++; $display("FAIL midframe_line: got %b expected 0 before reset", txd_a);
        end
        #1 anrst = 1'b0;
        #1;
        n_checks++;
        if (txd_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_async_line: got %b expected 1", txd_a);
        end
        repeat (3) @(negedge clk);
        anrst = 1'b1;
        zeros = 0;
        for (int s = 0; s < 400; s++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) zeros++;
        end
        n_checks++;
        if (zeros != 0) begin
            n_fail++; $display("FAIL no_residual_frame: got %0d low samples expected 0", zeros);
        end
        n_checks++;
        if (i_ready_a !== 1'b1 || o_valid_a !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_a: got i_ready=%b o_valid=%b expected 1 0", i_ready_a, o_valid_a);
        end
    endtask

    initial begin
        test_reset;
        test_tx_frames;
        test_parity;
        test_framing_and_glitch;
        test_overflow;
        test_timeout;
        test_reset_mid_tx;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
